// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: one multiplier or
// quotient bit per clock, stalls the pipeline via busy, registered one-cycle result.
module execute_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_in,
  input  logic            is_md,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_value
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opb;
  logic              neg_res, neg_rem;

  logic              start, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;

  logic [XLEN:0]     sum, shifted, diff;
  logic              q_bit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, result;

  assign start = v_in && is_md && !flush;

  // Operand decode: magnitudes, sign flags and the early-out divide cases.
  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_sgn && rs1_val[XLEN-1];
    b_neg    = b_sgn && rs2_val[XLEN-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = is_div && !funct3[0] &&
               (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = funct3[1] ? rs1_val : '1;
    else          special_val = funct3[1] ? '0 : rs1_val;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    q_bit   = (shifted >= {1'b0, opb});
    if (op[2]) begin
      if (q_bit) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else       acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
    prod_fix = neg_res ? -acc_nxt : acc_nxt;
    quo      = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem      = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : BUSY;
      BUSY: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      opb       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      res_rd    <= '0;
      res_value <= '0;
    end else if (state == IDLE && start) begin
      op     <= funct3;
      res_rd <= rd;
      if (special) begin
        res_value <= special_val;
      end else begin
        cnt     <= CW'(XLEN);
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        // Dividend/multiplier goes in the low half; the other operand stays fixed.
        acc     <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        opb     <= is_div ? b_mag : a_mag;
      end
    end else if (state == BUSY && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) res_value <= result;
    end
  end

  assign busy      = !rst && (state == BUSY || (state == IDLE && start));
  assign res_valid = (state == DONE) && !flush;

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomised and directed bench for execute_muldiv (XLEN=32 and XLEN=16 instances).
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_in, is_md, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;
  logic        busy, res_valid;
  logic [4:0]  res_rd;
  logic [31:0] res_value;

  logic        h_v_in, h_is_md, h_flush;
  logic [2:0]  h_funct3;
  logic [15:0] h_rs1_val, h_rs2_val;
  logic [4:0]  h_rd;
  logic        h_busy, h_res_valid;
  logic [4:0]  h_res_rd;
  logic [15:0] h_res_value;

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .v_in(v_in), .is_md(is_md), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .flush(flush),
    .busy(busy), .res_valid(res_valid), .res_rd(res_rd), .res_value(res_value)
  );

  execute_muldiv #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .v_in(h_v_in), .is_md(h_is_md), .funct3(h_funct3),
    .rs1_val(h_rs1_val), .rs2_val(h_rs2_val), .rd(h_rd), .flush(h_flush),
    .busy(h_busy), .res_valid(h_res_valid), .res_rd(h_res_rd), .res_value(h_res_value)
  );

  // RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    up = ua * ub;
    r  = '0;
    case (f)
      3'd0: r = up[31:0];
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); r = sp[63:32]; end
      3'd3: r = up[63:32];
      3'd4: if (b == 0) r = '1; else begin sp = sa / sb; r = sp[31:0]; end
      3'd5: if (b == 0) r = '1; else begin up = ua / ub; r = up[31:0]; end
      3'd6: if (b == 0) r = a;  else begin sp = sa % sb; r = sp[31:0]; end
      default: if (b == 0) r = a; else begin up = ua % ub; r = up[31:0]; end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one M op, hold it while stalled, then (unless hold) retire it.
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       input logic [31:0] exp_v, input bit hold);
    int lat, busy_n, vld_at;
    logic [31:0] got_v;
    logic [4:0]  got_rd;
    lat    = is_special(f, a, b) ? 1 : 33;
    busy_n = 0;
    vld_at = -1;
    got_v  = '0;
    got_rd = '0;
    @(posedge clk); #1;
    v_in = 1'b1; is_md = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd = r;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (res_valid) begin
        vld_at = c; got_v = res_value; got_rd = res_rd;
        break;
      end
    end
    n_checks++;
    if (vld_at !== lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, vld_at, lat);
    end
    n_checks++;
    if (busy_n !== lat) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, lat);
    end
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL %s value: got %h expected %h", name, got_v, exp_v);
    end
    n_checks++;
    if (got_rd !== r) begin
      n_fail++; $display("FAIL %s rd: got %0d expected %0d", name, got_rd, r);
    end
    if (!hold) begin
      @(posedge clk); #1;
      v_in = 1'b0; is_md = 1'b0;
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after: got valid=%b busy=%b expected 0/0", name, res_valid, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    v_in = 1'b1; is_md = 1'b1; funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd3; rd = 5'd9;
    h_v_in = 1'b0; h_is_md = 1'b0; h_flush = 1'b0; h_funct3 = '0;
    h_rs1_val = '0; h_rs2_val = '0; h_rd = '0;
    @(posedge clk); #2;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
    n_checks++;
    if (res_value !== 32'd0 || res_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_data: got %h/%0d expected 0/0", res_value, res_rd);
    end
    v_in = 1'b0; is_md = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_non_md;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      v_in = (c < 3); is_md = (c >= 3); funct3 = 3'($urandom_range(0, 7));
      rs1_val = $urandom; rs2_val = $urandom;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
        n_fail++; $display("FAIL non_md: got busy=%b valid=%b expected 0/0", busy, res_valid);
      end
    end
    @(posedge clk); #1;
    v_in = 1'b0; is_md = 1'b0;
  endtask

  task automatic test_directed;
    do_op("MUL",     3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    do_op("MULH",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    do_op("MULHU",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    do_op("MULHSU",  3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF, 1'b0);
    do_op("DIV",     3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, 1'b0);
    do_op("REM",     3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, 1'b0);
    do_op("DIVU",    3'd5, 32'd100,      32'd7,        5'd11, 32'd14,        1'b0);
    do_op("REMU",    3'd7, 32'd100,      32'd7,        5'd12, 32'd2,         1'b0);
    do_op("DIVU_z",  3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFF_FFFF, 1'b0);
    do_op("REM_z",   3'd6, 32'd5,        32'd0,        5'd14, 32'd5,         1'b0);
    do_op("DIV_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);
    do_op("REM_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0);
  endtask

  task automatic test_flush;
    int bad_busy, bad_vld;
    bad_busy = 0; bad_vld = 0;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        v_in = 1'b1; is_md = 1'b1; funct3 = 3'd0;
        rs1_val = 32'd1234; rs2_val = 32'd5678; rd = 5'd3;
      end
      if (c == 10) flush = 1'b1;
      if (c == 11) begin flush = 1'b0; v_in = 1'b0; is_md = 1'b0; end
      @(negedge clk);
      if (busy !== (c <= 10)) bad_busy++;
      if (res_valid !== 1'b0) bad_vld++;
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++; $display("FAIL flush_busy: got %0d wrong cycles expected 0", bad_busy);
    end
    n_checks++;
    if (bad_vld != 0) begin
      n_fail++; $display("FAIL flush_valid: got %0d valid cycles expected 0", bad_vld);
    end
    do_op("MUL_after_flush", 3'd0, 32'd3, 32'd4, 5'd4, 32'd12, 1'b0);
  endtask

  task automatic test_flush_done;
    int bad_vld;
    bad_vld = 0;
    for (int c = 0; c <= 36; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        v_in = 1'b1; is_md = 1'b1; funct3 = 3'd0;
        rs1_val = 32'd5; rs2_val = 32'd6; rd = 5'd2;
      end
      if (c == 33) flush = 1'b1;
      if (c == 34) begin flush = 1'b0; v_in = 1'b0; is_md = 1'b0; end
      @(negedge clk);
      if (res_valid !== 1'b0) bad_vld++;
    end
    n_checks++;
    if (bad_vld != 0) begin
      n_fail++; $display("FAIL flush_done: got %0d valid cycles expected 0", bad_vld);
    end
  endtask

  task automatic test_async_rst;
    int bad;
    @(posedge clk); #1;
    v_in = 1'b1; is_md = 1'b1; funct3 = 3'd3; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678;
    rd = 5'd21;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_ctrl: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
    n_checks++;
    if (res_value !== 32'd0 || res_rd !== 5'd0) begin
      n_fail++; $display("FAIL async_rst_data: got %h/%0d expected 0/0", res_value, res_rd);
    end
    @(negedge clk);
    rst = 1'b0; v_in = 1'b0; is_md = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_after: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    do_op("b2b_1", 3'd1, 32'hFFFF_FF00, 32'd77,  5'd17, ref_md(3'd1, 32'hFFFF_FF00, 32'd77), 1'b1);
    do_op("b2b_2", 3'd5, 32'd5,        32'd0,   5'd18, 32'hFFFF_FFFF, 1'b1);
    do_op("b2b_3", 3'd4, 32'd1000,     32'hFFFF_FFF6, 5'd19, 32'hFFFF_FF9C, 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    int mode;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) a = 32'($urandom_range(0, 255));
      do_op("random", f, a, b, 5'($urandom_range(0, 31)), ref_md(f, a, b), 1'b0);
    end
  endtask

  task automatic h_op(input string name, input logic [2:0] f, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_v, input int lat);
    int busy_n, vld_at;
    logic [15:0] got_v;
    busy_n = 0; vld_at = -1; got_v = '0;
    @(posedge clk); #1;
    h_v_in = 1'b1; h_is_md = 1'b1; h_funct3 = f; h_rs1_val = a; h_rs2_val = b; h_rd = 5'd30;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (h_busy) busy_n++;
      if (h_res_valid) begin vld_at = c; got_v = h_res_value; break; end
    end
    @(posedge clk); #1;
    h_v_in = 1'b0; h_is_md = 1'b0;
    n_checks++;
    if (vld_at !== lat || busy_n !== lat) begin
      n_fail++;
      $display("FAIL %s timing: got valid@%0d busy=%0d expected %0d", name, vld_at, busy_n, lat);
    end
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL %s value: got %h expected %h", name, got_v, exp_v);
    end
  endtask

  task automatic test_xlen16;
    h_op("x16_MULHU", 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    h_op("x16_DIV",   3'd4, 16'hFFF9, 16'd2,    16'hFFFD, 17);
    h_op("x16_ovf",   3'd4, 16'h8000, 16'hFFFF, 16'h8000, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_non_md;
    test_directed;
    test_flush;
    test_flush_done;
    test_async_rst;
    test_back_to_back;
    test_random;
    test_xlen16;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
